countdown_timer_bcd: RTL and testbench
======================================

Name: countdown_timer_bcd

Overview:
- Settable MM:SS countdown timer: the down-counting counterpart of the clock's up-counting mod-6/mod-10 digit chain.
- Loads four BCD digits and decrements once per external 1 Hz tick. Raises done and a timed alarm on reaching 00:00.
- Sits beside the clock datapath. Digit outputs feed the same 7-segment display mux as the time digits.

Parameters:
- ALARM_TICKS, 10, number of ticks alarm stays high after reaching 00:00 (1..15)
- MIN_T_MAX, 9, maximum legal minutes-tens digit

Ports:
- clk  input  1  system clock
- clr  input  1  reset; asynchronous, active-low
- tick  input  1  one-clk-wide 1 Hz enable pulse
- load  input  1  load ld_* digits (one-clk pulse)
- start  input  1  begin/resume counting (one-clk pulse)
- pause  input  1  suspend counting (one-clk pulse)
- ld_min_t  input  4  BCD minutes tens
- ld_min_u  input  4  BCD minutes units
- ld_sec_t  input  4  BCD seconds tens
- ld_sec_u  input  4  BCD seconds units
- min_t, min_u, sec_t, sec_u  output  4 each  current BCD digits
- running  output  1  high in RUN
- done  output  1  high in DONE
- alarm  output  1  high for ALARM_TICKS ticks after entering DONE
- load_err  output  1  one-clk pulse on rejected load

Behaviour:
- Reset (clr=0, asynchronous): all digits 0, state IDLE, running/done/alarm/load_err 0, alarm counter 0.
- All outputs are registered and update on posedge clk.
- States:
  - IDLE: no value running.
  - RUN: counting down.
  - PAUSE: counting suspended.
  - DONE: reached 00:00.
- Load:
  - Accepted in IDLE, PAUSE and DONE. Ignored in RUN, with no error pulse.
  - Legal digits: sec_u<=9, sec_t<=5, min_u<=9, min_t<=MIN_T_MAX.
  - Legal load: digits written next edge, state goes to IDLE, done/alarm cleared.
  - Illegal load: digits unchanged, load_err pulses one cycle.
- Start:
  - In IDLE or PAUSE with a nonzero value: go to RUN.
  - With value 00:00: ignored.
  - In RUN or DONE: no effect.
- Pause: in RUN goes to PAUSE. Ignored elsewhere.
- Tick in RUN decrements one second via a borrow chain:
  - sec_u 0->9 with borrow, else -1.
  - sec_t 0->5 with borrow (only on borrow in).
  - min_u 0->9 with borrow.
  - min_t -1 on borrow.
- Reaching zero: when the decrement yields 00:00, digits show 00:00 and state enters DONE on the same edge. done=1 and alarm=1 are visible from that edge.
- Alarm: counts ticks in DONE and falls after ALARM_TICKS ticks. done stays high until a legal load or reset.
- Ticks outside RUN are ignored.
- Simultaneous events, same cycle, priority order:
  - load > start
  - pause > start
  - tick+pause in RUN: decrement applied and state goes to PAUSE
  - tick+start in IDLE: start only, no decrement that cycle
- Reset mid-count aborts immediately to the reset values.

Optional Feature:
- Macro: AUTO_RELOAD_EN.
- Defined:
  - The last legal loaded value is held in a shadow register.
  - On reaching 00:00, the timer reloads the shadow value on the same edge and stays in RUN.
  - done pulses one cycle; alarm behaves as normal, counting ticks while running.
  - A shadow value of 00:00 falls back to the plain DONE behaviour.
- Undefined: no shadow register; behaviour exactly as above.

Decomposition:
- Shared include file (timer_defs.vh) holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3
  - digit limit localparams SEC_T_MAX=5, DIGIT_MAX=9
- One natural sub-module, bcd_down_digit:
  - Parameter MAX; inputs dec and ld/ld_val; outputs q and borrow_out (combinational borrow when q==0 and dec).
  - Same async active-low clr.
  - Instantiated four times in a chain.

Test Plan:
- Reset then load 01:05, start, 6 ticks -> digits 01:04,01:03,01:02,01:01,01:00,00:59; running=1.
- Load 00:02, start, 2 ticks -> 00:01 then 00:00 with done=1, alarm=1, running=0. ALARM_TICKS=10 further ticks -> alarm=0, done still 1.
- Load with ld_sec_t=6 (or ld_sec_u=4'hA) -> load_err one-cycle pulse, digits unchanged, state unchanged.
- In RUN at 10:00, pause+tick same cycle -> 09:59, PAUSE; 3 ticks -> still 09:59. Start, 1 tick -> 09:58.
- Load 00:00, start -> stays IDLE, running=0. Load 99:59 -> accepted. Reset asserted mid-count -> all digits 0 immediately, state IDLE.
- With AUTO_RELOAD_EN and load 00:03: after 3 ticks -> digits 00:03, done one-cycle pulse, running stays 1.

Source files
------------

// File: rtl/countdown_timer_bcd_pkg.sv
// Shared definitions for the MM:SS countdown timer: FSM state encoding,
// BCD digit limits and the load-legality check.
package countdown_timer_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SEC_T_MAX = 5;
    localparam int DIGIT_MAX = 9;

    // A load value is usable only if every digit stays inside its own modulus.
    function automatic logic bcd_time_legal(input logic [3:0] mt,
                                            input logic [3:0] mu,
                                            input logic [3:0] st,
                                            input logic [3:0] su,
                                            input logic [3:0] mt_max);
        return (su <= 4'(DIGIT_MAX)) && (st <= 4'(SEC_T_MAX)) &&
               (mu <= 4'(DIGIT_MAX)) && (mt <= mt_max);
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_bcd_down_digit.sv
// One BCD down-counting digit with wrap-to-MAX and a combinational borrow,
// chained four times to form the MM:SS countdown.
module bcd_down_digit #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       dec,
    output logic [3:0] q,
    output logic       borrow_out
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    assign borrow_out = dec && (q == 4'd0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= ld_val;
        end else if (dec) begin
            q <= (q == 4'd0) ? MAX_V : q - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Settable MM:SS countdown timer driven by a 1 Hz tick, with done and timed alarm.
// Optional build macro AUTO_RELOAD_EN: reload the last legal value at 00:00 and keep running.
module countdown_timer_bcd
    import countdown_timer_bcd_pkg::*;
#(
    parameter int ALARM_TICKS = 10,
    parameter int MIN_T_MAX   = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] ld_min_t,
    input  logic [3:0] ld_min_u,
    input  logic [3:0] ld_sec_t,
    input  logic [3:0] ld_sec_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err,
    output logic [1:0] state_dbg
);

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS - 1);

    state_t      state;
    logic [3:0]  alarm_cnt;
    logic [15:0] ld_vec;
    logic [15:0] dig_val;
    logic        ld_legal;
    logic        ld_ok;
    logic        digits_zero;
    logic        one_left;
    logic        hits_zero;
    logic        reload;
    logic        dig_ld;
    logic        dec_su;
    logic        bor_su;
    logic        bor_st;
    logic        bor_mu;
    logic        bor_mt;

    assign ld_vec      = {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u};
    assign ld_legal    = bcd_time_legal(ld_min_t, ld_min_u, ld_sec_t, ld_sec_u, 4'(MIN_T_MAX));
    assign ld_ok       = load && (state != ST_RUN) && ld_legal;
    assign digits_zero = ({min_t, min_u, sec_t, sec_u} == 16'h0000);
    assign one_left    = ({min_t, min_u, sec_t, sec_u} == 16'h0001);
    assign dec_su      = tick && (state == ST_RUN);
    // A borrow out of the top digit cannot occur from a nonzero value; treat it as terminal anyway.
    assign hits_zero   = (dec_su && one_left) || bor_mt;
    assign state_dbg   = state;

`ifdef AUTO_RELOAD_EN
    logic [15:0] shadow;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shadow <= 16'h0000;
        end else if (ld_ok) begin
            shadow <= ld_vec;
        end
    end

    assign reload  = hits_zero && (shadow != 16'h0000);
    assign dig_val = reload ? shadow : ld_vec;
`else
    assign reload  = 1'b0;
    assign dig_val = ld_vec;
`endif

    assign dig_ld = ld_ok || reload;

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_u (
        .clk(clk), .clr(clr), .ld(dig_ld), .ld_val(dig_val[3:0]),
        .dec(dec_su), .q(sec_u), .borrow_out(bor_su)
    );

    bcd_down_digit #(.MAX(SEC_T_MAX)) u_sec_t (
        .clk(clk), .clr(clr), .ld(dig_ld), .ld_val(dig_val[7:4]),
        .dec(bor_su), .q(sec_t), .borrow_out(bor_st)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_u (
        .clk(clk), .clr(clr), .ld(dig_ld), .ld_val(dig_val[11:8]),
        .dec(bor_st), .q(min_u), .borrow_out(bor_mu)
    );

    bcd_down_digit #(.MAX(MIN_T_MAX)) u_min_t (
        .clk(clk), .clr(clr), .ld(dig_ld), .ld_val(dig_val[15:12]),
        .dec(bor_mu), .q(min_t), .borrow_out(bor_mt)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= 4'd0;
            load_err  <= 1'b0;
        end else begin
            load_err <= 1'b0;

            if (alarm && tick) begin
                if (alarm_cnt == ALARM_LAST) begin
                    alarm     <= 1'b0;
                    alarm_cnt <= 4'd0;
                end else begin
                    alarm_cnt <= alarm_cnt + 4'd1;
                end
            end

            // Any load outside RUN consumes the cycle, so a coincident start is dropped.
            if (load && (state != ST_RUN)) begin
                if (ld_legal) begin
                    state     <= ST_IDLE;
                    running   <= 1'b0;
                    done      <= 1'b0;
                    alarm     <= 1'b0;
                    alarm_cnt <= 4'd0;
                end else begin
                    load_err <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !digits_zero) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (start && !pause && !digits_zero) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        done <= 1'b0;
                        if (hits_zero) begin
                            done      <= 1'b1;
                            alarm     <= 1'b1;
                            alarm_cnt <= 4'd0;
                            if (!reload) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                            end
                        end else if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd: per-cycle expected outputs
// queued at drive time and compared one edge later.
module tb_countdown_timer_bcd;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef logic [21:0] obs_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       tick, load, start, pause;
    logic [3:0] ld_min_t, ld_min_u, ld_sec_t, ld_sec_u;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, done, alarm, load_err;
    logic [1:0] state_dbg;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] seq1 [6] = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};

    countdown_timer_bcd #(.ALARM_TICKS(10), .MIN_T_MAX(9)) dut (
        .clk(clk), .clr(clr), .tick(tick), .load(load), .start(start), .pause(pause),
        .ld_min_t(ld_min_t), .ld_min_u(ld_min_u), .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .done(done), .alarm(alarm), .load_err(load_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic obs_t ex(input logic [1:0] st, input logic [15:0] d,
                                input logic r, input logic dn, input logic al, input logic er);
        return {st, d, r, dn, al, er};
    endfunction

    function automatic obs_t observed();
        return {state_dbg, min_t, min_u, sec_t, sec_u, running, done, alarm, load_err};
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h (state,mmss,run,done,alarm,err)", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic t, input logic l, input logic s,
                       input logic p, input logic [15:0] ldv, input obs_t e);
        tick  = t;
        load  = l;
        start = s;
        pause = p;
        {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = ldv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        check(tag, observed(), exp_q.pop_front());
    endtask

    task automatic tk(input string tag, input obs_t e);
        cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, e);
    endtask

    task automatic gap(input obs_t e);
        int n;
        n = $urandom_range(0, 2);
        repeat (n) cyc("gap", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, e);
    endtask

    initial begin
        clr = 1'b0;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(ex(S_IDLE, 16'h0000, 0, 0, 0, 0));
        check("reset", observed(), exp_q.pop_front());
        clr = 1'b1;

        // Basic countdown with borrow across seconds-tens.
        cyc("load_0105", 0, 1, 0, 0, 16'h0105, ex(S_IDLE, 16'h0105, 0, 0, 0, 0));
        cyc("start_0105", 0, 0, 1, 0, 16'h0000, ex(S_RUN, 16'h0105, 1, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            tk("tick_seq1", ex(S_RUN, seq1[i], 1, 0, 0, 0));
            gap(ex(S_RUN, seq1[i], 1, 0, 0, 0));
        end
        cyc("load_in_run", 0, 1, 0, 0, 16'h0200, ex(S_RUN, 16'h0059, 1, 0, 0, 0));
        cyc("bad_load_in_run", 0, 1, 0, 0, 16'h0060, ex(S_RUN, 16'h0059, 1, 0, 0, 0));
        cyc("pause", 0, 0, 0, 1, 16'h0000, ex(S_PAUSE, 16'h0059, 0, 0, 0, 0));
        cyc("pause_beats_start", 0, 0, 1, 1, 16'h0000, ex(S_PAUSE, 16'h0059, 0, 0, 0, 0));
        tk("tick_in_pause", ex(S_PAUSE, 16'h0059, 0, 0, 0, 0));

        // Illegal loads leave digits and state alone and pulse load_err.
        cyc("bad_sec_t", 0, 1, 0, 0, 16'h0060, ex(S_PAUSE, 16'h0059, 0, 0, 0, 1));
        cyc("err_clears", 0, 0, 0, 0, 16'h0000, ex(S_PAUSE, 16'h0059, 0, 0, 0, 0));
        cyc("bad_sec_u", 0, 1, 0, 0, 16'h000A, ex(S_PAUSE, 16'h0059, 0, 0, 0, 1));
        cyc("bad_min_t", 0, 1, 0, 0, 16'hA000, ex(S_PAUSE, 16'h0059, 0, 0, 0, 1));

`ifndef AUTO_RELOAD_EN
        cyc("load_0002", 0, 1, 0, 0, 16'h0002, ex(S_IDLE, 16'h0002, 0, 0, 0, 0));
        cyc("start_0002", 0, 0, 1, 0, 16'h0000, ex(S_RUN, 16'h0002, 1, 0, 0, 0));
        tk("tick_0001", ex(S_RUN, 16'h0001, 1, 0, 0, 0));
        tk("reach_zero", ex(S_DONE, 16'h0000, 0, 1, 1, 0));
        cyc("start_in_done", 0, 0, 1, 0, 16'h0000, ex(S_DONE, 16'h0000, 0, 1, 1, 0));
        for (int i = 1; i <= 10; i++) begin
            tk("alarm_count", ex(S_DONE, 16'h0000, 0, 1, (i < 10), 0));
        end
        cyc("bad_load_in_done", 0, 1, 0, 0, 16'h0060, ex(S_DONE, 16'h0000, 0, 1, 0, 1));
`else
        cyc("load_0003", 0, 1, 0, 0, 16'h0003, ex(S_IDLE, 16'h0003, 0, 0, 0, 0));
        cyc("start_0003", 0, 0, 1, 0, 16'h0000, ex(S_RUN, 16'h0003, 1, 0, 0, 0));
        tk("tick_0002", ex(S_RUN, 16'h0002, 1, 0, 0, 0));
        tk("tick_0001", ex(S_RUN, 16'h0001, 1, 0, 0, 0));
        tk("auto_reload", ex(S_RUN, 16'h0003, 1, 1, 1, 0));
        cyc("done_pulse_ends", 0, 0, 0, 0, 16'h0000, ex(S_RUN, 16'h0003, 1, 0, 1, 0));
        tk("run_after_reload", ex(S_RUN, 16'h0002, 1, 0, 1, 0));
        cyc("pause_auto", 0, 0, 0, 1, 16'h0000, ex(S_PAUSE, 16'h0002, 0, 0, 1, 0));
`endif

        // Tick and pause together: decrement lands, then counting stops.
        cyc("load_1000", 0, 1, 0, 0, 16'h1000, ex(S_IDLE, 16'h1000, 0, 0, 0, 0));
        cyc("start_1000", 0, 0, 1, 0, 16'h0000, ex(S_RUN, 16'h1000, 1, 0, 0, 0));
        cyc("tick_pause", 1, 0, 0, 1, 16'h0000, ex(S_PAUSE, 16'h0959, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tk("tick_paused", ex(S_PAUSE, 16'h0959, 0, 0, 0, 0));
        end
        cyc("resume", 0, 0, 1, 0, 16'h0000, ex(S_RUN, 16'h0959, 1, 0, 0, 0));
        tk("tick_0958", ex(S_RUN, 16'h0958, 1, 0, 0, 0));
        cyc("pause_start_run", 0, 0, 1, 1, 16'h0000, ex(S_PAUSE, 16'h0958, 0, 0, 0, 0));

        // Zero value, load/start and tick/start priorities, full-range load.
        cyc("load_0000", 0, 1, 0, 0, 16'h0000, ex(S_IDLE, 16'h0000, 0, 0, 0, 0));
        cyc("start_zero", 0, 0, 1, 0, 16'h0000, ex(S_IDLE, 16'h0000, 0, 0, 0, 0));
        cyc("load_beats_start", 0, 1, 1, 0, 16'h0003, ex(S_IDLE, 16'h0003, 0, 0, 0, 0));
        cyc("tick_start_idle", 1, 0, 1, 0, 16'h0000, ex(S_RUN, 16'h0003, 1, 0, 0, 0));
        cyc("pause_0003", 0, 0, 0, 1, 16'h0000, ex(S_PAUSE, 16'h0003, 0, 0, 0, 0));
        cyc("load_9959", 0, 1, 0, 0, 16'h9959, ex(S_IDLE, 16'h9959, 0, 0, 0, 0));
        cyc("start_9959", 0, 0, 1, 0, 16'h0000, ex(S_RUN, 16'h9959, 1, 0, 0, 0));
        tk("tick_9958", ex(S_RUN, 16'h9958, 1, 0, 0, 0));
        tk("tick_9957", ex(S_RUN, 16'h9957, 1, 0, 0, 0));

        // Asynchronous reset in the middle of a clock period.
        #2;
        clr = 1'b0;
        #1;
        exp_q.push_back(ex(S_IDLE, 16'h0000, 0, 0, 0, 0));
        check("async_reset", observed(), exp_q.pop_front());
        cyc("reset_held", 1, 0, 1, 0, 16'h0000, ex(S_IDLE, 16'h0000, 0, 0, 0, 0));
        clr = 1'b1;
        tk("tick_idle_after_reset", ex(S_IDLE, 16'h0000, 0, 0, 0, 0));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
